// File: rtl/hazard_scoreboard.sv
// Hazard detection between IF and ID: a shadow pipeline of in-flight instructions is
// compared against the fetched instruction to produce stall/bubble requests and a stall counter.
module hazard_scoreboard #(
  parameter int REG_AW     = 3,
  parameter int DEPTH      = 4,
  parameter int FWD_EN     = 0,
  parameter int MEM_CHK    = 1,
  parameter int ADDR_W     = 16,
  parameter int BR_BUBBLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [REG_AW-1:0] if_rs,
  input  logic              if_rs_used,
  input  logic [REG_AW-1:0] if_rt,
  input  logic              if_rt_used,
  input  logic [REG_AW-1:0] if_rd,
  input  logic              if_rd_wr,
  input  logic              if_is_load,
  input  logic              if_mem_wr,
  input  logic [ADDR_W-1:0] if_mem_addr,
  input  logic              if_ctrl_xfer,
  input  logic              flush,
  output logic              stall,
  output logic              nop,
  output logic [1:0]        haz_cause,
  output logic [15:0]       stall_cnt
);

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  wr_q;
  logic [DEPTH-1:0]  ld_q;
  logic [DEPTH-1:0]  st_q;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [3:0]        bub_q, bub_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [DEPTH-1:0]  reg_hit;
  logic [DEPTH-1:0]  mem_hit;
  logic              reg_haz, mem_haz, ctrl_haz;
  logic              stall_int, accept;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic src_match;
      assign src_match = (if_rs_used & (rd_q[gi] == if_rs)) |
                         (if_rt_used & (rd_q[gi] == if_rt));
      // With forwarding only a load still sitting in ID cannot supply its result in time.
      if (FWD_EN == 0) begin : g_nofwd
        assign reg_hit[gi] = v_q[gi] & wr_q[gi] & src_match;
      end else if (gi == 0) begin : g_fwd_id
        assign reg_hit[gi] = v_q[gi] & wr_q[gi] & ld_q[gi] & src_match;
      end else begin : g_fwd_late
        assign reg_hit[gi] = 1'b0;
      end
      assign mem_hit[gi] = v_q[gi] & st_q[gi] & (addr_q[gi] == if_mem_addr);
    end
  endgenerate

  assign reg_haz  = if_valid & (|reg_hit);
  assign mem_haz  = (MEM_CHK != 0) & if_valid & if_is_load & (|mem_hit);
  assign ctrl_haz = (bub_q != 4'd0);

  always_comb begin
    stall_int = 1'b0;
    nop       = 1'b0;
    haz_cause = 2'd0;
    if (rst_n) begin
      if (flush) begin
        nop       = 1'b1;
        haz_cause = 2'd3;
      end else begin
        stall_int = reg_haz | mem_haz | ctrl_haz;
        nop       = stall_int;
        if (ctrl_haz)     haz_cause = 2'd3;
        else if (reg_haz) haz_cause = 2'd1;
        else if (mem_haz) haz_cause = 2'd2;
      end
    end
  end

  assign stall     = stall_int;
  assign accept    = if_valid & ~stall_int & ~flush;
  assign stall_cnt = cnt_q;

  always_comb begin
    bub_d = bub_q;
    if (flush)                        bub_d = 4'd0;
    else if (accept & if_ctrl_xfer)   bub_d = 4'(BR_BUBBLES);
    else if (bub_q != 4'd0)           bub_d = bub_q - 4'd1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_int && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      wr_q  <= '0;
      ld_q  <= '0;
      st_q  <= '0;
      bub_q <= 4'd0;
      cnt_q <= 16'd0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= '0;
        addr_q[k] <= '0;
      end
    end else begin
      v_q   <= flush ? '0 : {v_q[DEPTH-2:0], accept};
      wr_q  <= {wr_q[DEPTH-2:0], if_rd_wr};
      ld_q  <= {ld_q[DEPTH-2:0], if_is_load};
      st_q  <= {st_q[DEPTH-2:0], if_mem_wr};
      bub_q <= bub_d;
      cnt_q <= cnt_d;
      rd_q[0]   <= if_rd;
      addr_q[0] <= if_mem_addr;
      for (int k = 1; k < DEPTH; k++) begin
        rd_q[k]   <= rd_q[k-1];
        addr_q[k] <= addr_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Three scoreboard flavours (no forwarding, forwarding, memory check off) driven by shared
// stimulus and compared each cycle against an accept-time based reference model.
module tb_hazard_scoreboard;
  localparam int DEPTH = 4;
  localparam int BB    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_rs_used, if_rt_used, if_rd_wr, if_is_load, if_mem_wr;
  logic        if_ctrl_xfer, flush;
  logic [2:0]  if_rs, if_rt, if_rd;
  logic [15:0] if_mem_addr;
  logic        stall_o [3];
  logic        nop_o   [3];
  logic [1:0]  cause_o [3];
  logic [15:0] cnt_o   [3];

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(3), .DEPTH(DEPTH), .FWD_EN(0), .MEM_CHK(1), .ADDR_W(16), .BR_BUBBLES(BB))
  u_nofwd (.clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_rs(if_rs), .if_rs_used(if_rs_used),
    .if_rt(if_rt), .if_rt_used(if_rt_used), .if_rd(if_rd), .if_rd_wr(if_rd_wr), .if_is_load(if_is_load),
    .if_mem_wr(if_mem_wr), .if_mem_addr(if_mem_addr), .if_ctrl_xfer(if_ctrl_xfer), .flush(flush),
    .stall(stall_o[0]), .nop(nop_o[0]), .haz_cause(cause_o[0]), .stall_cnt(cnt_o[0]));

  hazard_scoreboard #(.REG_AW(3), .DEPTH(DEPTH), .FWD_EN(1), .MEM_CHK(1), .ADDR_W(16), .BR_BUBBLES(BB))
  u_fwd (.clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_rs(if_rs), .if_rs_used(if_rs_used),
    .if_rt(if_rt), .if_rt_used(if_rt_used), .if_rd(if_rd), .if_rd_wr(if_rd_wr), .if_is_load(if_is_load),
    .if_mem_wr(if_mem_wr), .if_mem_addr(if_mem_addr), .if_ctrl_xfer(if_ctrl_xfer), .flush(flush),
    .stall(stall_o[1]), .nop(nop_o[1]), .haz_cause(cause_o[1]), .stall_cnt(cnt_o[1]));

  hazard_scoreboard #(.REG_AW(3), .DEPTH(DEPTH), .FWD_EN(0), .MEM_CHK(0), .ADDR_W(16), .BR_BUBBLES(BB))
  u_nomem (.clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_rs(if_rs), .if_rs_used(if_rs_used),
    .if_rt(if_rt), .if_rt_used(if_rt_used), .if_rd(if_rd), .if_rd_wr(if_rd_wr), .if_is_load(if_is_load),
    .if_mem_wr(if_mem_wr), .if_mem_addr(if_mem_addr), .if_ctrl_xfer(if_ctrl_xfer), .flush(flush),
    .stall(stall_o[2]), .nop(nop_o[2]), .haz_cause(cause_o[2]), .stall_cnt(cnt_o[2]));

  typedef struct {
    int          inst;
    int          t;
    logic [2:0]  rd;
    logic        wr;
    logic        ld;
    logic        st;
    logic [15:0] addr;
  } rec_t;

  rec_t q[$];
  int   last_flush [3];
  int   last_br    [3];
  int   exp_cnt    [3];
  logic obs_stall  [3];
  int   cyc;
  int   vectors;
  int   miscompares;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // An instruction accepted in cycle t occupies stage (cyc-t-1) while that is below DEPTH,
  // unless a flush or reset happened after it was accepted.
  function automatic void model(input int i, output logic s, output logic n, output logic [1:0] c);
    logic rh, mh, ch;
    int   age;
    rh = 1'b0;
    mh = 1'b0;
    foreach (q[j]) begin
      if (q[j].inst == i && q[j].t < cyc && cyc <= q[j].t + DEPTH && q[j].t > last_flush[i]) begin
        age = cyc - q[j].t - 1;
        if (q[j].wr && ((if_rs_used && q[j].rd == if_rs) || (if_rt_used && q[j].rd == if_rt)) &&
            (i != 1 || (age == 0 && q[j].ld)))
          rh = 1'b1;
        if (i != 2 && if_is_load && q[j].st && q[j].addr == if_mem_addr)
          mh = 1'b1;
      end
    end
    rh = rh & if_valid;
    mh = mh & if_valid;
    ch = (last_br[i] > last_flush[i]) && (cyc > last_br[i]) && (cyc - last_br[i] <= BB);
    if (flush) begin
      s = 1'b0; n = 1'b1; c = 2'd3;
    end else begin
      s = rh | mh | ch;
      n = s;
      c = ch ? 2'd3 : rh ? 2'd1 : mh ? 2'd2 : 2'd0;
    end
  endfunction

  task automatic cycle();
    logic       s, n;
    logic [1:0] c;
    rec_t       r;
    #4;
    for (int i = 0; i < 3; i++) begin
      model(i, s, n, c);
      check_eq($sformatf("stall[%0d]", i), 32'(stall_o[i]), 32'(s));
      check_eq($sformatf("nop[%0d]", i), 32'(nop_o[i]), 32'(n));
      check_eq($sformatf("cause[%0d]", i), 32'(cause_o[i]), 32'(c));
      check_eq($sformatf("cnt[%0d]", i), 32'(cnt_o[i]), 32'(exp_cnt[i]));
      obs_stall[i] = stall_o[i];
      if (if_valid && !s && !flush) begin
        r.inst = i; r.t = cyc; r.rd = if_rd; r.wr = if_rd_wr;
        r.ld = if_is_load; r.st = if_mem_wr; r.addr = if_mem_addr;
        q.push_back(r);
        if (if_ctrl_xfer) last_br[i] = cyc;
      end
      if (flush) last_flush[i] = cyc;
      if (s && exp_cnt[i] < 65535) exp_cnt[i]++;
    end
    for (int j = q.size() - 1; j >= 0; j--)
      if (q[j].t + DEPTH < cyc) q.delete(j);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drv(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                     input logic rtu, input logic [2:0] rd, input logic wr, input logic ld,
                     input logic st, input logic [15:0] addr, input logic cx, input logic fl);
    if_valid = v; if_rs = rs; if_rs_used = rsu; if_rt = rt; if_rt_used = rtu;
    if_rd = rd; if_rd_wr = wr; if_is_load = ld; if_mem_wr = st; if_mem_addr = addr;
    if_ctrl_xfer = cx; flush = fl;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    repeat (n) cycle();
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_stall[%0d]", tag, i), 32'(stall_o[i]), 32'd0);
      check_eq($sformatf("%s_nop[%0d]", tag, i), 32'(nop_o[i]), 32'd0);
      check_eq($sformatf("%s_cause[%0d]", tag, i), 32'(cause_o[i]), 32'd0);
      check_eq($sformatf("%s_cnt[%0d]", tag, i), 32'(cnt_o[i]), 32'd0);
    end
  endtask

  initial begin
    int n, nc;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      last_flush[i] = -50; last_br[i] = -100; exp_cnt[i] = 0;
    end
    rst_n = 1'b0;
    drv(1, 3, 1, 0, 0, 3, 1, 0, 0, 16'h0, 0, 1);
    #3;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    idle(0);
    rst_n = 1'b1;

    // producer rd=3 then consumer of r3: four stall cycles without forwarding
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 16'h0, 0, 0); cycle();
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (obs_stall[0]) n++; else break;
    end
    check_eq("raw_bubbles", 32'(n), 32'd4);
    check_eq("raw_stall_cnt", 32'(cnt_o[0]), 32'd4);
    idle(6);

    // load-use with forwarding: one bubble; ALU result forwarded: none
    drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 16'h10, 0, 0); cycle();
    drv(1, 2, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (obs_stall[1]) n++; else break;
    end
    check_eq("load_use_bubbles", 32'(n), 32'd1);
    idle(6);
    drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 16'h0, 0, 0); cycle();
    drv(1, 0, 0, 2, 1, 0, 0, 0, 0, 16'h0, 0, 0); cycle();
    check_eq("alu_fwd_no_stall", 32'(obs_stall[1]), 32'd0);
    idle(6);

    // store -> load same address stalls until the store retires; check disabled in u_nomem
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0040, 0, 0); cycle();
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 16'h0040, 0, 0);
    n = 0; nc = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (obs_stall[2]) nc++;
      if (obs_stall[0]) n++; else break;
    end
    check_eq("mem_raw_bubbles", 32'(n), 32'd4);
    check_eq("mem_chk_off_bubbles", 32'(nc), 32'd0);
    idle(6);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0040, 0, 0); cycle();
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 16'h0042, 0, 0); cycle();
    check_eq("mem_other_addr", 32'(obs_stall[0]), 32'd0);
    idle(6);

    // branch bubbles, then flush inside the first bubble clears counter and producers
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0); cycle();
    idle(3);
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 16'h0, 0, 0); cycle();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0); cycle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1); cycle();
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0); cycle();
    check_eq("flush_clears_raw", 32'(obs_stall[0]), 32'd0);
    idle(6);

    // source match without use, and producer without write: no stall
    drv(1, 0, 0, 0, 0, 4, 0, 0, 0, 16'h0, 0, 0); cycle();
    drv(1, 4, 1, 4, 1, 0, 0, 0, 0, 16'h0, 0, 0); cycle();
    drv(1, 0, 0, 0, 0, 6, 1, 0, 0, 16'h0, 0, 0); cycle();
    drv(1, 6, 0, 6, 0, 0, 0, 0, 0, 16'h0, 0, 0); cycle();
    check_eq("unused_src_no_stall", 32'(obs_stall[0]), 32'd0);
    idle(6);

    // asynchronous reset in the middle of a stall
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 16'h0, 0, 0); cycle();
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0); cycle();
    check_eq("pre_reset_stall", 32'(obs_stall[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    for (int i = 0; i < 3; i++) begin
      last_flush[i] = cyc; exp_cnt[i] = 0;
    end
    q.delete();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      drv(($urandom % 8) != 0, 3'($urandom % 4), 1'($urandom % 2), 3'($urandom % 4),
          1'($urandom % 2), 3'($urandom % 4), 1'($urandom % 2), ($urandom % 4) == 0,
          ($urandom % 4) == 0, 16'h40 + 16'(2 * ($urandom % 3)), ($urandom % 8) == 0,
          ($urandom % 16) == 0);
      if (if_is_load) if_mem_wr = 1'b0;
      cycle();
    end

    // self-dependent branches keep u_nofwd stalled most cycles until the counter saturates
    drv(1, 3, 1, 0, 0, 3, 1, 0, 0, 16'h0, 1, 0);
    for (int k = 0; k < 90000 && exp_cnt[0] < 65535; k++) cycle();
    repeat (20) cycle();
    check_eq("stall_cnt_saturated", 32'(cnt_o[0]), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
